// File: rtl/pwr_rail_sequencer_if.sv
// Rail enable / power-good bundle between the sequencer (master) and the rail
// regulators or delay timers (slave).
interface pwr_rail_sequencer_if #(
    parameter int NUM_RAILS = 4
);
    logic [NUM_RAILS-1:0] RAIL_EN;
    logic [NUM_RAILS-1:0] RAIL_PG;

    modport master (output RAIL_EN, input RAIL_PG);
    modport slave  (input RAIL_EN, output RAIL_PG);
endinterface

// File: rtl/pwr_rail_sequencer.sv
// Baseboard power sequencer: brings rails up in order gated on PG with a per-rail
// timeout, powers down in reverse with a fixed gap, and latches faults.
module pwr_rail_sequencer #(
    parameter int              NUM_RAILS  = 4,
    parameter int              CNT_W      = 16,
    parameter logic [CNT_W-1:0] PG_TIMEOUT = 16'hC350,
    parameter logic [CNT_W-1:0] OFF_GAP    = 16'h2710
) (
    input  logic                   SYSCLK,
    input  logic                   RESET_N,
    input  logic                   PWR_ON_REQ,
    pwr_rail_sequencer_if.master   rail,
    output logic                   SEQ_DONE,
    output logic                   SEQ_FAULT,
    output logic [2:0]             FAULT_RAIL,
    output logic [2:0]             SEQ_STATE
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ON_EN   = 3'd1,
        ON_WAIT = 3'd2,
        ON_DONE = 3'd3,
        OFF_DIS = 3'd4,
        OFF_GAP_ST = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [2:0]       LAST_IDX     = 3'(NUM_RAILS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = PG_TIMEOUT - 1'b1;
    localparam logic [CNT_W-1:0] GAP_LAST     = OFF_GAP - 1'b1;

    state_t                 state_reg, state_next;
    logic [2:0]             idx_reg, idx_next;
    logic [CNT_W-1:0]       timer_reg, timer_next;
    logic [NUM_RAILS-1:0]   rail_en_reg, rail_en_next;
    logic                   fault_reg, fault_next;
    logic [2:0]             fault_rail_reg, fault_rail_next;

    logic                   req_meta_reg, req_s_reg;
    logic [NUM_RAILS-1:0]   pg_meta_reg, pg_s_reg;

    logic [NUM_RAILS-1:0]   idx_onehot;
    logic [NUM_RAILS-1:0]   below_mask;
    logic [NUM_RAILS-1:0]   loss_below;
    logic                   go_fault;
    logic [2:0]             go_fault_idx;

    function automatic logic [2:0] lowest_set(input logic [NUM_RAILS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign idx_onehot = NUM_RAILS'(1) << idx_reg;

    // Rails already enabled below the one being waited on must hold PG.
    for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_below
        assign below_mask[gi] = (3'(gi) < idx_reg);
    end
    assign loss_below = below_mask & ~pg_s_reg;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_meta_reg <= 1'b0;
            req_s_reg    <= 1'b0;
            pg_meta_reg  <= '0;
            pg_s_reg     <= '0;
        end else begin
            req_meta_reg <= PWR_ON_REQ;
            req_s_reg    <= req_meta_reg;
            pg_meta_reg  <= rail.RAIL_PG;
            pg_s_reg     <= pg_meta_reg;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            timer_reg      <= '0;
            rail_en_reg    <= '0;
            fault_reg      <= 1'b0;
            fault_rail_reg <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            timer_reg      <= timer_next;
            rail_en_reg    <= rail_en_next;
            fault_reg      <= fault_next;
            fault_rail_reg <= fault_rail_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        timer_next      = timer_reg;
        rail_en_next    = rail_en_reg;
        fault_next      = fault_reg;
        fault_rail_next = fault_rail_reg;
        go_fault        = 1'b0;
        go_fault_idx    = '0;

        case (state_reg)
            IDLE: begin
                rail_en_next = '0;
                if (req_s_reg) begin
                    state_next      = ON_EN;
                    idx_next        = '0;
                    fault_rail_next = '0;
                end
            end
            ON_EN: begin
                rail_en_next = rail_en_reg | idx_onehot;
                timer_next   = '0;
                state_next   = ON_WAIT;
            end
            ON_WAIT: begin
                timer_next = timer_reg + 1'b1;
                if (!req_s_reg) begin
                    state_next = OFF_DIS;
                end else if (|loss_below) begin
                    go_fault     = 1'b1;
                    go_fault_idx = lowest_set(loss_below);
                end else if (|(pg_s_reg & idx_onehot)) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ON_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ON_EN;
                    end
                end else if (timer_reg == TIMEOUT_LAST) begin
                    go_fault     = 1'b1;
                    go_fault_idx = idx_reg;
                end
            end
            ON_DONE: begin
                if (!req_s_reg) begin
                    state_next = OFF_DIS;
                    idx_next   = LAST_IDX;
                end else if (|(~pg_s_reg)) begin
                    go_fault     = 1'b1;
                    go_fault_idx = lowest_set(~pg_s_reg);
                end
            end
            OFF_DIS: begin
                rail_en_next = rail_en_reg & ~idx_onehot;
                timer_next   = '0;
                state_next   = (idx_reg == '0) ? IDLE : OFF_GAP_ST;
            end
            OFF_GAP_ST: begin
                timer_next = timer_reg + 1'b1;
                if (timer_reg == GAP_LAST) begin
                    idx_next   = idx_reg - 1'b1;
                    state_next = OFF_DIS;
                end
            end
            FAULT: begin
                if (!req_s_reg) begin
                    state_next = IDLE;
                    fault_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // All rails drop together on the edge that enters FAULT.
        if (go_fault) begin
            state_next      = FAULT;
            rail_en_next    = '0;
            fault_next      = 1'b1;
            fault_rail_next = go_fault_idx;
        end
    end

    assign rail.RAIL_EN = rail_en_reg;
    assign SEQ_DONE     = (state_reg == ON_DONE);
    assign SEQ_FAULT    = fault_reg;
    assign FAULT_RAIL   = fault_rail_reg;
    assign SEQ_STATE    = state_reg;
endmodule

// File: tb/tb_pwr_rail_sequencer.sv
// Randomized bench for pwr_rail_sequencer: a simulated rail plant answers the
// enables, and a cycle-level reference model predicts every output each cycle.
module tb_pwr_rail_sequencer;
    localparam int N = 4;
    localparam int T = 16;
    localparam int G = 8;

    logic       SYSCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       PWR_ON_REQ = 1'b0;
    logic       SEQ_DONE, SEQ_FAULT;
    logic [2:0] FAULT_RAIL, SEQ_STATE;

    pwr_rail_sequencer_if #(.NUM_RAILS(N)) rail ();

    pwr_rail_sequencer #(
        .NUM_RAILS (N),
        .CNT_W     (16),
        .PG_TIMEOUT(16'd16),
        .OFF_GAP   (16'd8)
    ) dut (
        .SYSCLK    (SYSCLK),
        .RESET_N   (RESET_N),
        .PWR_ON_REQ(PWR_ON_REQ),
        .rail      (rail.master),
        .SEQ_DONE  (SEQ_DONE),
        .SEQ_FAULT (SEQ_FAULT),
        .FAULT_RAIL(FAULT_RAIL),
        .SEQ_STATE (SEQ_STATE)
    );

    always #20 SYSCLK = ~SYSCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: spec state numbers, rails on as a count of the lowest rails.
    int           m_state, m_idx, m_timer, m_non, m_fault, m_frail;
    logic         m_req_m, m_req_s;
    logic [N-1:0] m_pg_m, m_pg_s;

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_timer = 0; m_non = 0; m_fault = 0; m_frail = 0;
        m_req_m = 1'b0; m_req_s = 1'b0; m_pg_m = '0; m_pg_s = '0;
    endtask

    function automatic int lowest_low(input logic [N-1:0] pg, input int below);
        for (int i = 0; i < below; i++) if (!pg[i]) return i;
        return -1;
    endfunction

    task automatic enter_fault(input int r);
        m_state = 6; m_non = 0; m_fault = 1; m_frail = r;
    endtask

    task automatic model_edge(input logic req, input logic [N-1:0] pg);
        int lo;
        int old_timer;
        old_timer = m_timer;
        case (m_state)
            0: if (m_req_s) begin m_state = 1; m_idx = 0; m_frail = 0; end
            1: begin m_non = m_idx + 1; m_timer = 0; m_state = 2; end
            2: begin
                m_timer = old_timer + 1;
                lo = lowest_low(m_pg_s, m_idx);
                if (!m_req_s) m_state = 4;
                else if (lo >= 0) enter_fault(lo);
                else if (m_pg_s[m_idx]) begin
                    if (m_idx == N - 1) m_state = 3;
                    else begin m_idx++; m_state = 1; end
                end else if (old_timer == T - 1) enter_fault(m_idx);
            end
            3: begin
                lo = lowest_low(m_pg_s, N);
                if (!m_req_s) begin m_state = 4; m_idx = N - 1; end
                else if (lo >= 0) enter_fault(lo);
            end
            4: begin
                m_non = m_idx; m_timer = 0;
                m_state = (m_idx == 0) ? 0 : 5;
            end
            5: begin
                m_timer = old_timer + 1;
                if (old_timer == G - 1) begin m_idx--; m_state = 4; end
            end
            6: if (!m_req_s) begin m_state = 0; m_fault = 0; end
            default: m_state = 0;
        endcase
        m_req_s = m_req_m; m_req_m = req;
        m_pg_s  = m_pg_m;  m_pg_m  = pg;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_en;
        exp_en = N'((1 << m_non) - 1);
        check_eq("rail_en",    rail.RAIL_EN, exp_en);
        check_eq("seq_done",   SEQ_DONE,     (m_state == 3) ? 1 : 0);
        check_eq("seq_fault",  SEQ_FAULT,    m_fault);
        check_eq("fault_rail", FAULT_RAIL,   m_frail);
        check_eq("seq_state",  SEQ_STATE,    m_state);
    endtask

    // Rail plant: PG follows EN after a per-rail delay; dead rails never report PG.
    int           on_cnt [N];
    int           dly    [N];
    int           glitch [N];
    logic [N-1:0] dead;

    task automatic plant_update();
        logic [N-1:0] pg;
        if ($urandom_range(299) == 0) glitch[$urandom_range(N - 1)] = $urandom_range(4, 1);
        for (int k = 0; k < N; k++) begin
            on_cnt[k] = rail.RAIL_EN[k] ? on_cnt[k] + 1 : 0;
            pg[k] = rail.RAIL_EN[k] && !dead[k] && (on_cnt[k] >= dly[k]) && (glitch[k] == 0);
            if (glitch[k] > 0) glitch[k]--;
        end
        rail.RAIL_PG = pg;
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        if (!RESET_N) model_reset();
        else model_edge(PWR_ON_REQ, rail.RAIL_PG);
        #1;
        check_outputs();
        plant_update();
    endtask

    initial begin
        int hi, lo, waited;
        rail.RAIL_PG = '0;
        dead = '0;
        for (int k = 0; k < N; k++) begin on_cnt[k] = 0; dly[k] = 5; glitch[k] = 0; end
        model_reset();
        #5;
        check_outputs();
        repeat (3) tick();
        #10 RESET_N = 1'b1;

        for (int e = 0; e < 40; e++) begin
            for (int k = 0; k < N; k++) dly[k] = (e == 0) ? 5 : int'($urandom_range(15, 1));
            dead = (e != 0 && $urandom_range(3) == 0) ? N'(1) << $urandom_range(N - 1) : '0;
            hi = (e == 0) ? 120 : int'($urandom_range(150, 10));
            lo = int'($urandom_range(80, 10));
            PWR_ON_REQ = 1'b1;
            repeat (hi) tick();
            PWR_ON_REQ = 1'b0;
            for (int c = 0; c < lo; c++) begin
                if (c == lo / 3 && $urandom_range(1) == 1) PWR_ON_REQ = 1'b1;
                if (c == lo / 3 + 2) PWR_ON_REQ = 1'b0;
                tick();
            end
            PWR_ON_REQ = 1'b0;
            $display("episode %0d: dly=%0d/%0d/%0d/%0d dead=%b hi=%0d lo=%0d end_state=%0d",
                     e, dly[0], dly[1], dly[2], dly[3], dead, hi, lo, m_state);
        end

        // Asynchronous reset while fully powered.
        for (int k = 0; k < N; k++) dly[k] = 2;
        dead = '0;
        repeat (80) tick();
        PWR_ON_REQ = 1'b1;
        waited = 0;
        while (SEQ_STATE != 3'd3 && waited < 200) begin tick(); waited++; end
        check_eq("reach_on_done", SEQ_STATE, 3);
        check_eq("all_rails_on", rail.RAIL_EN, 4'hF);
        #10 RESET_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("async_rst_en", rail.RAIL_EN, 0);
        repeat (2) tick();
        #10 RESET_N = 1'b1;
        repeat (40) tick();
        $display("async reset: state=%0d en=%b", m_state, rail.RAIL_EN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
